// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one access in flight,
// with a data-burst limit so a pending fetch cannot starve.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int D_BURST = 4,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_cancel,
    output logic                if_ready,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [CNT_W-1:0]    conflict_cnt
);

    localparam int BE_W    = DATA_W / 8;
    localparam int BURST_W = $clog2(D_BURST + 1);

    arb_state_t          state_reg, state_next;
    logic [BURST_W-1:0]  burst_cnt_reg, burst_cnt_next;
    logic                discard_reg, discard_next;
    logic [CNT_W-1:0]    conflict_cnt_reg;
    logic                mem_req_reg, mem_we_reg;
    logic [BE_W-1:0]     mem_be_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;
    logic                eff_if, grant_d, grant_i;

    // A cancelled fetch never competes for the port.
    assign eff_if = if_req & ~if_cancel;

    always_comb begin
        state_next     = state_reg;
        burst_cnt_next = burst_cnt_reg;
        discard_next   = discard_reg;
        grant_d        = 1'b0;
        grant_i        = 1'b0;
        if_ready       = 1'b0;
        d_ready        = 1'b0;
        case (state_reg)
            IDLE: begin
                discard_next = 1'b0;
                if (d_req && (!eff_if || burst_cnt_reg < BURST_W'(D_BURST))) begin
                    grant_d        = 1'b1;
                    state_next     = WAIT_D;
                    burst_cnt_next = eff_if ? burst_cnt_reg + BURST_W'(1) : '0;
                end else if (eff_if) begin
                    grant_i        = 1'b1;
                    state_next     = WAIT_I;
                    burst_cnt_next = '0;
                end else begin
                    burst_cnt_next = '0;
                end
            end
            WAIT_I: begin
                if_ready = mem_ack & ~discard_reg & ~if_cancel;
                if (mem_ack) begin
                    state_next   = IDLE;
                    discard_next = 1'b0;
                end else if (if_cancel) begin
                    discard_next = 1'b1;
                end
            end
            WAIT_D: begin
                d_ready = mem_ack;
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            burst_cnt_reg <= '0;
            discard_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            burst_cnt_reg <= burst_cnt_next;
            discard_reg   <= discard_next;
        end
    end

    // Command register: attributes hold between grants, the strobe lasts one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_be_reg    <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            mem_req_reg <= grant_d | grant_i;
            if (grant_d) begin
                mem_we_reg    <= d_we;
                mem_be_reg    <= d_be;
                mem_addr_reg  <= d_addr;
                mem_wdata_reg <= d_wdata;
            end else if (grant_i) begin
                mem_we_reg   <= 1'b0;
                mem_be_reg   <= '1;
                mem_addr_reg <= if_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt_reg <= '0;
        end else if (state_reg == IDLE && if_req && d_req && conflict_cnt_reg != '1) begin
            conflict_cnt_reg <= conflict_cnt_reg + CNT_W'(1);
        end
    end

    assign mem_req      = mem_req_reg;
    assign mem_we       = mem_we_reg;
    assign mem_be       = mem_be_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign if_rdata     = mem_rdata;
    assign d_rdata      = mem_rdata;
    assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single shared memory port of the pipelined MIPS CPU between instruction fetch (IF stage) and data access (MEM stage). Each accepted request is issued as a one-cycle command. The block then waits for the memory acknowledge and returns read data and a ready strobe to the winning requester. Ready strobes drive the pipeline stall logic. IF fetches can be cancelled by a branch flush, and a data-burst limit prevents IF starvation.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables = DATA_W/8)
D_BURST, 4, maximum consecutive data grants while if_req is pending
CNT_W, 16, width of the conflict counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  IF fetch request; held until if_ready or cancel
if_addr  in  ADDR_W  fetch address (PC)
if_cancel  in  1  branch flush; drop current or pending fetch
if_ready  out  1  fetch complete, one cycle, combinational from mem_ack
if_rdata  out  DATA_W  instruction, valid when if_ready
d_req  in  1  data request; held until d_ready
d_we  in  1  1 = store, 0 = load
d_be  in  DATA_W/8  byte enables for a store
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ready  out  1  data access complete, one cycle, combinational from mem_ack
d_rdata  out  DATA_W  load data, valid when d_ready
mem_req  out  1  one-cycle command strobe (registered)
mem_we  out  1  registered write enable
mem_be  out  DATA_W/8  registered byte enables
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_ack  in  1  memory completion pulse, at least 1 cycle after mem_req
mem_rdata  in  DATA_W  read data, valid with mem_ack
conflict_cnt  out  CNT_W  count of IDLE cycles with if_req and d_req both high; saturates

Behaviour:
- Reset (async, high): state IDLE.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata = 0.
  - burst_cnt = 0, discard = 0, conflict_cnt = 0.
  - if_ready and d_ready = 0, since they are gated by state.
- States:
  - IDLE: no access outstanding.
  - WAIT_I: fetch outstanding.
  - WAIT_D: data access outstanding.
- IDLE arbitration: evaluated every cycle with eff_if = if_req & ~if_cancel.
  - Data wins when d_req and (~eff_if or burst_cnt < D_BURST).
  - Otherwise IF wins when eff_if.
  - Otherwise stay in IDLE.
- Grant issue: registered at the next edge.
  - mem_req = 1 for exactly one cycle.
  - mem_addr, mem_we, mem_be, mem_wdata loaded from the winner.
  - IF grants force mem_we = 0 and mem_be = all ones.
  - Next state is WAIT_D or WAIT_I.
- burst_cnt:
  - Increments on a data grant while eff_if is high.
  - Clears on an IF grant or when eff_if is low in IDLE.
- WAIT_D: d_ready = mem_ack and d_rdata = mem_rdata. On mem_ack, next state is IDLE.
- WAIT_I:
  - if_ready = mem_ack & ~discard & ~if_cancel; if_rdata = mem_rdata.
  - if_cancel sets discard.
  - On mem_ack, next state is IDLE and discard clears.
  - A response cancelled in the same cycle is suppressed.
- Requester contract: drop or replace the request at the edge after ready. Arbitration in IDLE then sees fresh inputs. Minimum turnaround is request seen at T, mem_req at T+1, ack at T+2 or later, next grant one cycle after the ack.
- mem_ack while IDLE (e.g. a late ack after reset): ignored, no ready strobe.
- No new mem_req while a WAIT state is outstanding; at most one access in flight.
- conflict_cnt holds at all ones and never wraps.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, WAIT_I=2'd1, WAIT_D=2'd2); the ADDR_W, DATA_W defaults.
- No sub-module needed. Optional mem_port_arb_fsm split is not warranted; keep everything in one module.

Test Plan:
- Lone load: d_req, d_addr=0x40, mem_ack 2 cycles after mem_req with rdata=0xDEADBEEF -> mem_req 1 cycle, mem_we=0, d_ready 1 cycle with d_rdata=0xDEADBEEF, if_ready stays 0.
- Simultaneous if_req (addr 0x100) and d_req (store 0x44, data 0x12345678, be 4'hF) in IDLE -> store issued first with mem_we=1; fetch of 0x100 issued after d_ready; conflict_cnt=1.
- Continuous d_req with if_req held high, D_BURST=4 -> grants D,D,D,D,I,D...; fetch completes after exactly 4 data accesses.
- if_cancel asserted in WAIT_I, mem_ack 3 cycles later -> if_ready never asserts, returns to IDLE, next fetch issues normally. Repeat with cancel coincident with mem_ack -> suppressed.
- reset pulsed mid-WAIT_D, memory acks afterwards -> all outputs 0 immediately, stray ack ignored, d_ready stays 0.
- conflict_cnt saturation with CNT_W=2 -> holds at 3 after 5 conflict cycles.
